block_transfer_sequencer: RTL and testbench

// - Sequences LDM/STM multi-register transfers through register_file's single rd write port and rn read port.
// - Walks a 16-bit register list lowest-first, one memory beat per register.
// - Computes IA/IB/DA/DB addresses and the optional base writeback.
// - Sits between decode/execute control and register_file + data-memory port; core stalls while busy=1.

---
 rtl/block_transfer_sequencer_pkg.sv | 40 ++++
 rtl/block_transfer_sequencer_if.sv | 48 ++++
 rtl/block_transfer_sequencer_lowest_set_encoder.sv | 22 ++
 rtl/block_transfer_sequencer.sv | 142 ++++++++++++++
 tb/tb_block_transfer_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_transfer_sequencer_pkg.sv
// Shared widths, state encodings and helpers for the LDM/STM block transfer sequencer.
package block_transfer_sequencer_pkg;

    localparam int unsigned WORD_SIZE  = 32;
    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned CNT_WIDTH  = $clog2(NUM_REGS + 1);

    localparam logic [WORD_SIZE-1:0] BEAT_BYTES = WORD_SIZE'(4);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Transfer attributes captured when a start is accepted.
    typedef struct packed {
        logic                  is_load;
        logic                  wb_en;
        logic [ADDR_WIDTH-1:0] base_reg;
    } xfer_cmd_t;

    // Lowest memory address of the block; beats always ascend from here.
    function automatic logic [WORD_SIZE-1:0] first_beat_addr(
        input logic [WORD_SIZE-1:0] base,
        input logic [WORD_SIZE-1:0] span,
        input logic                 up,
        input logic                 pre
    );
        logic [WORD_SIZE-1:0] a;
        case ({up, pre})
            2'b10:   a = base;
            2'b11:   a = base + BEAT_BYTES;
            2'b00:   a = base - span + BEAT_BYTES;
            default: a = base - span;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/block_transfer_sequencer_if.sv
// Control, data-memory and register-file signals seen by the block transfer sequencer.
interface block_transfer_sequencer_if;
    import block_transfer_sequencer_pkg::*;

    logic                  start;
    logic                  is_load;
    logic [NUM_REGS-1:0]   reg_list;
    logic [WORD_SIZE-1:0]  base_addr;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic                  up;
    logic                  pre;
    logic                  writeback;

    logic                  mem_req;
    logic                  mem_we;
    logic [WORD_SIZE-1:0]  mem_addr;
    logic [WORD_SIZE-1:0]  mem_wdata;
    logic                  mem_ready;
    logic [WORD_SIZE-1:0]  mem_rdata;

    logic [ADDR_WIDTH-1:0] rf_read_rn;
    logic [WORD_SIZE-1:0]  rf_rn_out;
    logic                  rf_rd_we;
    logic [ADDR_WIDTH-1:0] rf_write_rd;
    logic [WORD_SIZE-1:0]  rf_rd_in;

    logic                  busy;
    logic                  done;

    // Sequencer side.
    modport master (
        input  start, is_load, reg_list, base_addr, base_reg, up, pre, writeback,
        input  mem_ready, mem_rdata, rf_rn_out,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output rf_read_rn, rf_rd_we, rf_write_rd, rf_rd_in,
        output busy, done
    );

    // Decode/execute, data memory and register file side.
    modport slave (
        output start, is_load, reg_list, base_addr, base_reg, up, pre, writeback,
        output mem_ready, mem_rdata, rf_rn_out,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  rf_read_rn, rf_rd_we, rf_write_rd, rf_rd_in,
        input  busy, done
    );

endinterface

// File: rtl/block_transfer_sequencer_lowest_set_encoder.sv
// Index of the lowest set bit of a register mask, with a non-empty flag.
module lowest_set_encoder
    import block_transfer_sequencer_pkg::*;
(
    input  logic [NUM_REGS-1:0]   mask,
    output logic [ADDR_WIDTH-1:0] index_c,
    output logic                  valid_c
);

    // Scan high to low so the lowest set bit is the final assignment.
    always_comb begin
        index_c = '0;
        valid_c = 1'b0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index_c = ADDR_WIDTH'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_transfer_sequencer.sv
// Walks an LDM/STM register list lowest-first, one memory beat per register,
// with optional base writeback after the last beat.
module block_transfer_sequencer (
    input  logic                        clk,
    input  logic                        reset,
    block_transfer_sequencer_if.master  bus
);
    import block_transfer_sequencer_pkg::*;

    logic [1:0]            state_q, state_d;
    logic [NUM_REGS-1:0]   mask_q, mask_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d;
    logic [WORD_SIZE-1:0]  wb_value_q, wb_value_d;
    xfer_cmd_t             cmd_q, cmd_d;

    logic [CNT_WIDTH-1:0]  pop_c;
    logic [WORD_SIZE-1:0]  span_c;
    logic [ADDR_WIDTH-1:0] cur_c;
    logic                  cur_valid_c;
    logic [NUM_REGS-1:0]   cur_onehot_c;
    logic                  last_beat_c;

    lowest_set_encoder u_lowest_set_encoder (
        .mask    (mask_q),
        .index_c (cur_c),
        .valid_c (cur_valid_c)
    );

    // Number of registers in the incoming list and the byte span they cover.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pop_c = pop_c + CNT_WIDTH'(bus.reg_list[i]);
        end
        span_c = WORD_SIZE'(pop_c) << 2;
    end

    // Current register as a mask bit, and whether it is the final one.
    always_comb begin
        cur_onehot_c = NUM_REGS'(1) << cur_c;
        last_beat_c  = (mask_q & ~cur_onehot_c) == '0;
    end

    // State and latched transfer context.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            addr_q     <= '0;
            wb_value_q <= '0;
            cmd_q      <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            wb_value_q <= wb_value_d;
            cmd_q      <= cmd_d;
        end
    end

    // Next state, context updates and per-state outputs.
    always_comb begin
        state_d         = state_q;
        mask_d          = mask_q;
        addr_d          = addr_q;
        wb_value_d      = wb_value_q;
        cmd_d           = cmd_q;

        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.rf_read_rn  = '0;
        bus.rf_rd_we    = 1'b0;
        bus.rf_write_rd = '0;
        bus.rf_rd_in    = '0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cmd_d.is_load  = bus.is_load;
                    // A loaded base register keeps the loaded value, so no writeback then.
                    cmd_d.wb_en    = bus.writeback && (pop_c != '0) &&
                                     !(bus.is_load && bus.reg_list[bus.base_reg]);
                    cmd_d.base_reg = bus.base_reg;
                    mask_d         = bus.reg_list;
                    addr_d         = first_beat_addr(bus.base_addr, span_c, bus.up, bus.pre);
                    wb_value_d     = bus.up ? (bus.base_addr + span_c) : (bus.base_addr - span_c);
                    state_d        = (pop_c == '0) ? ST_DONE : ST_XFER;
                end
            end

            ST_XFER: begin
                bus.busy = 1'b1;
                if (!cur_valid_c) begin
                    state_d = ST_DONE;
                end else begin
                    bus.mem_req    = 1'b1;
                    bus.mem_we     = !cmd_q.is_load;
                    bus.mem_addr   = addr_q;
                    bus.rf_read_rn = cur_c;
                    if (!cmd_q.is_load) begin
                        bus.mem_wdata = bus.rf_rn_out;
                    end
                    if (bus.mem_ready) begin
                        if (cmd_q.is_load) begin
                            bus.rf_rd_we    = 1'b1;
                            bus.rf_write_rd = cur_c;
                            bus.rf_rd_in    = bus.mem_rdata;
                        end
                        mask_d = mask_q & ~cur_onehot_c;
                        addr_d = addr_q + BEAT_BYTES;
                        if (last_beat_c) begin
                            state_d = cmd_q.wb_en ? ST_WB : ST_DONE;
                        end
                    end
                end
            end

            ST_WB: begin
                bus.busy        = 1'b1;
                bus.rf_rd_we    = 1'b1;
                bus.rf_write_rd = cmd_q.base_reg;
                bus.rf_rd_in    = wb_value_q;
                state_d         = ST_DONE;
            end

            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Randomized self-checking bench for block_transfer_sequencer.
module tb_block_transfer_sequencer;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [31:0] rf_model [16];

    block_transfer_sequencer_if bus_if ();

    block_transfer_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    assign bus_if.rf_rn_out = rf_model[bus_if.rf_read_rn];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic randomize_cmd_inputs();
        bus_if.is_load   = 1'($urandom_range(1, 0));
        bus_if.reg_list  = 16'($urandom);
        bus_if.base_addr = $urandom;
        bus_if.base_reg  = 4'($urandom_range(15, 0));
        bus_if.up        = 1'($urandom_range(1, 0));
        bus_if.pre       = 1'($urandom_range(1, 0));
        bus_if.writeback = 1'($urandom_range(1, 0));
    endtask

    // One full transfer, checked every cycle against a beat schedule chosen up front.
    task automatic run_xfer(input string name, input logic ld, input logic [15:0] list,
                            input logic [31:0] base, input logic [3:0] breg,
                            input logic u, input logic p, input logic w,
                            input int max_wait, input int slow_beat, input logic disturb);
        int          regq[$];
        int          ends[$];
        int          n, t, done_c, b, wt;
        logic [31:0] span, start_a, wbv, rdata;
        logic        wb_en, ready;
        logic        e_req, e_we, e_rfwe, e_busy, e_done, stm_beat;
        logic [31:0] e_addr, e_wdata, e_rfdata;
        logic [3:0]  e_rn, e_wr;

        for (int i = 0; i < 16; i++) if (list[i]) regq.push_back(i);
        n    = regq.size();
        span = 32'(4 * n);
        case ({u, p})
            2'b10:   start_a = base;
            2'b11:   start_a = base + 32'd4;
            2'b00:   start_a = base - span + 32'd4;
            default: start_a = base - span;
        endcase
        wbv   = u ? base + span : base - span;
        wb_en = w && (n > 0) && !(ld && list[breg]);
        t = 0;
        for (int k = 0; k < n; k++) begin
            wt = (k == slow_beat) ? 3 : ((max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0);
            t += wt + 1;
            ends.push_back(t);
        end
        done_c = t + 1 + int'(wb_en);

        bus_if.is_load   = ld;
        bus_if.reg_list  = list;
        bus_if.base_addr = base;
        bus_if.base_reg  = breg;
        bus_if.up        = u;
        bus_if.pre       = p;
        bus_if.writeback = w;
        bus_if.start     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        randomize_cmd_inputs();

        b = 0;
        for (int c = 1; c <= done_c + 1; c++) begin
            if (b < n - 1 && c > ends[b]) b++;
            ready = (c <= t) ? (c == ends[b]) : 1'($urandom_range(1, 0));
            rdata = $urandom;
            bus_if.mem_ready = ready;
            bus_if.mem_rdata = rdata;
            if (disturb && c == 2 && c <= done_c) begin
                randomize_cmd_inputs();
                bus_if.start = 1'b1;
            end else begin
                bus_if.start = 1'b0;
            end

            e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_rn = '0; stm_beat = 1'b0;
            e_rfwe = 1'b0; e_wr = '0; e_rfdata = '0; e_wdata = '0;
            if (c <= t) begin
                e_req    = 1'b1;
                e_we     = !ld;
                e_addr   = start_a + 32'(4 * b);
                e_rn     = 4'(regq[b]);
                stm_beat = !ld;
                e_wdata  = rf_model[e_rn];
                if (ld && ready) begin
                    e_rfwe = 1'b1; e_wr = e_rn; e_rfdata = rdata;
                end
            end else if (wb_en && c == t + 1) begin
                e_rfwe = 1'b1; e_wr = breg; e_rfdata = wbv;
            end
            e_done = (c == done_c);
            e_busy = (c <= done_c);

            @(negedge clk);
            n_tests++;
            if (bus_if.mem_req !== e_req) begin
                n_fail++;
                $display("FAIL %s c%0d mem_req got %0b want %0b", name, c, bus_if.mem_req, e_req);
            end
            n_tests++;
            if (bus_if.rf_read_rn !== e_rn) begin
                n_fail++;
                $display("FAIL %s c%0d rf_read_rn got %0d want %0d", name, c, bus_if.rf_read_rn, e_rn);
            end
            n_tests++;
            if (bus_if.rf_rd_we !== e_rfwe) begin
                n_fail++;
                $display("FAIL %s c%0d rf_rd_we got %0b want %0b", name, c, bus_if.rf_rd_we, e_rfwe);
            end
            n_tests++;
            if (bus_if.busy !== e_busy) begin
                n_fail++;
                $display("FAIL %s c%0d busy got %0b want %0b", name, c, bus_if.busy, e_busy);
            end
            n_tests++;
            if (bus_if.done !== e_done) begin
                n_fail++;
                $display("FAIL %s c%0d done got %0b want %0b", name, c, bus_if.done, e_done);
            end
            if (e_req) begin
                n_tests++;
                if (bus_if.mem_addr !== e_addr || bus_if.mem_we !== e_we) begin
                    n_fail++;
                    $display("FAIL %s c%0d mem_addr/we got %h/%0b want %h/%0b",
                             name, c, bus_if.mem_addr, bus_if.mem_we, e_addr, e_we);
                end
            end
            if (stm_beat) begin
                n_tests++;
                if (bus_if.mem_wdata !== e_wdata) begin
                    n_fail++;
                    $display("FAIL %s c%0d mem_wdata got %h want %h", name, c, bus_if.mem_wdata, e_wdata);
                end
            end
            if (e_rfwe) begin
                n_tests++;
                if (bus_if.rf_write_rd !== e_wr || bus_if.rf_rd_in !== e_rfdata) begin
                    n_fail++;
                    $display("FAIL %s c%0d rf write got R%0d=%h want R%0d=%h",
                             name, c, bus_if.rf_write_rd, bus_if.rf_rd_in, e_wr, e_rfdata);
                end
            end
            @(posedge clk);
            #1;
        end
        bus_if.start     = 1'b0;
        bus_if.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = '0;
        randomize_cmd_inputs();
        for (int i = 0; i < 16; i++) rf_model[i] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.rf_read_rn,
             bus_if.rf_rd_we, bus_if.rf_write_rd, bus_if.rf_rd_in, bus_if.busy, bus_if.done} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got req=%0b busy=%0b done=%0b we=%0b addr=%h want all 0",
                     bus_if.mem_req, bus_if.busy, bus_if.done, bus_if.rf_rd_we, bus_if.mem_addr);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset idle busy got %0b want 0", bus_if.busy);
        end
    endtask

    task automatic test_stm_ia();
        run_xfer("stm_ia", 1'b0, 16'h000E, 32'h0000_0100, 4'd0, 1'b1, 1'b0, 1'b0, 0, -1, 1'b0);
    endtask

    task automatic test_ldm_db_wb();
        run_xfer("ldm_db_wb", 1'b1, 16'h0011, 32'h0000_0200, 4'd13, 1'b0, 1'b1, 1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_ldm_base_in_list();
        run_xfer("ldm_base_in_list", 1'b1, 16'h0004, 32'h0000_0300, 4'd2, 1'b1, 1'b0, 1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_empty_list();
        run_xfer("empty_stm", 1'b0, 16'h0000, 32'h0000_0400, 4'd5, 1'b1, 1'b1, 1'b1, 0, -1, 1'b0);
        run_xfer("empty_ldm", 1'b1, 16'h0000, 32'h0000_0404, 4'd6, 1'b0, 1'b0, 1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_wait_and_ignore_start();
        run_xfer("wait_stm", 1'b0, 16'h00F0, 32'h0000_1000, 4'd1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b1);
        run_xfer("wait_ldm", 1'b1, 16'h8421, 32'h0000_2000, 4'd3, 1'b1, 1'b1, 1'b1, 0, 1, 1'b1);
    endtask

    task automatic test_wrap();
        run_xfer("wrap_db", 1'b0, 16'hFFFF, 32'h0000_0010, 4'd0, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0);
        run_xfer("wrap_ib", 1'b1, 16'h8001, 32'hFFFF_FFFC, 4'd7, 1'b1, 1'b1, 1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_xfer();
        bus_if.is_load   = 1'b0;
        bus_if.reg_list  = 16'h0F0F;
        bus_if.base_addr = 32'h0000_3000;
        bus_if.base_reg  = 4'd9;
        bus_if.up        = 1'b1;
        bus_if.pre       = 1'b0;
        bus_if.writeback = 1'b1;
        bus_if.mem_ready = 1'b0;
        bus_if.start     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.rf_read_rn,
             bus_if.rf_rd_we, bus_if.rf_write_rd, bus_if.rf_rd_in, bus_if.busy, bus_if.done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_xfer outputs got req=%0b busy=%0b addr=%h rn=%0d want all 0",
                     bus_if.mem_req, bus_if.busy, bus_if.mem_addr, bus_if.rf_read_rn);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_xfer("after_reset", 1'b1, 16'h0003, 32'h0000_4000, 4'd0, 1'b1, 1'b0, 1'b1, 1, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] list;
        logic [3:0]  breg;
        for (int it = 0; it < 40; it++) begin
            list = 16'($urandom);
            if ($urandom_range(7, 0) == 0) list = '0;
            breg = 4'($urandom_range(15, 0));
            if ($urandom_range(3, 0) == 0) list[breg] = 1'b1;
            run_xfer("random", 1'($urandom_range(1, 0)), list, $urandom, breg,
                     1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                     int'($urandom_range(2, 0)), -1, 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 6; it++) begin
            run_xfer("back_to_back", 1'(it % 2), 16'($urandom) | 16'h0001, $urandom,
                     4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                     1'b1, 0, -1, 1'b0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_stm_ia();
        test_ldm_db_wb();
        test_ldm_base_in_list();
        test_empty_list();
        test_wait_and_ignore_start();
        test_wrap();
        test_reset_mid_xfer();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
